// File: rtl/score_bcd_encoder.sv
// Score binary-to-BCD converter (shift-and-add-3, one bit per clock) with leading-zero mask and saturation flag.
// Latency BIN_W cycles from accepted start to done; start is ignored (not queued) while busy.
module score_bcd_encoder #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  ovf
);

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) p = p * 32'd10;
        return p;
    endfunction

    localparam int               BCD_W   = 4 * DIGITS;
    localparam int               CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(BIN_W - 1);
    localparam logic [31:0]      MAX_VAL = pow10(DIGITS) - 32'd1;

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t             state, state_n;
    logic [BIN_W-1:0]   bin_q, bin_n;
    logic [BCD_W-1:0]   scratch, scratch_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               pend_ovf, pend_ovf_n;
    logic [BCD_W-1:0]   bcd_n;
    logic [DIGITS-1:0]  digit_en_n;
    logic               ovf_n, done_n;

    logic [BCD_W-1:0]   corrected, shifted;
    logic [DIGITS-1:0]  mask;
    logic [31:0]        bin_wide;
    logic               seen_nz;

    assign bin_wide = 32'(bin);
    assign busy     = (state == CONVERT);

    always_comb begin
        corrected = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                corrected[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        // The corrected top bit is always zero here, so the truncating cast drops nothing.
        shifted = BCD_W'({corrected, bin_q[BIN_W-1]});

        mask    = '0;
        seen_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen_nz = seen_nz | (|shifted[4*i +: 4]);
            mask[i] = seen_nz;
        end
        mask[0] = 1'b1;
    end

    always_comb begin
        state_n    = state;
        bin_n      = bin_q;
        scratch_n  = scratch;
        cnt_n      = cnt;
        pend_ovf_n = pend_ovf;
        bcd_n      = bcd_out;
        digit_en_n = digit_en;
        ovf_n      = ovf;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (bin_wide > MAX_VAL) begin
                        bin_n      = MAX_VAL[BIN_W-1:0];
                        pend_ovf_n = 1'b1;
                    end else begin
                        bin_n      = bin;
                        pend_ovf_n = 1'b0;
                    end
                    scratch_n = '0;
                    cnt_n     = '0;
                    state_n   = CONVERT;
                end
            end
            CONVERT: begin
                scratch_n = shifted;
                bin_n     = bin_q << 1;
                cnt_n     = cnt + CNT_W'(1);
                if (cnt == LAST) begin
                    bcd_n      = shifted;
                    digit_en_n = mask;
                    ovf_n      = pend_ovf;
                    done_n     = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bin_q    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            pend_ovf <= 1'b0;
            bcd_out  <= '0;
            digit_en <= DIGITS'(1);
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            bin_q    <= bin_n;
            scratch  <= scratch_n;
            cnt      <= cnt_n;
            pend_ovf <= pend_ovf_n;
            bcd_out  <= bcd_n;
            digit_en <= digit_en_n;
            ovf      <= ovf_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_score_bcd_encoder.sv
// Bench for score_bcd_encoder: directed and random conversions checked against a decimal-arithmetic model.
module tb_score_bcd_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        busy, done, ovf;
    logic [15:0] bcd_out;
    logic [3:0]  digit_en;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] prev_bcd = 16'h0000;
    logic [3:0]  prev_den = 4'b0001;
    logic        prev_ovf = 1'b0;

    score_bcd_encoder #(.BIN_W(14), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd_out(bcd_out),
        .digit_en(digit_en), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        s = sat(v);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [3:0] ref_den(input int v);
        int s;
        s = sat(v);
        return {s >= 1000, s >= 100, s >= 10, 1'b1};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; returns on a negedge with start low.
    task automatic convert(input int v, input bit noisy);
        int k, busy_n, glitch;
        logic [15:0] eb;
        logic [3:0]  ed;
        logic        eo;
        eb = ref_bcd(v);
        ed = ref_den(v);
        eo = (v > 9999);
        start = 1'b1;
        bin   = 14'(v);
        @(posedge clk);
        k = 0; busy_n = 0; glitch = 0;
        @(negedge clk);
        while (k < 40) begin
            if (done) break;
            if (busy) busy_n++;
            if (bcd_out !== prev_bcd || digit_en !== prev_den || ovf !== prev_ovf) glitch++;
            start = noisy ? 1'($urandom) : 1'b0;
            bin   = 14'($urandom);
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("latency v=%0d", v), 32'(k), 32'd14);
        check($sformatf("busy_cycles v=%0d", v), 32'(busy_n), 32'd14);
        check($sformatf("no_glitch v=%0d", v), 32'(glitch), 32'd0);
        check($sformatf("busy_at_done v=%0d", v), 32'(busy), 32'd0);
        check($sformatf("bcd v=%0d", v), 32'(bcd_out), 32'(eb));
        check($sformatf("digit_en v=%0d", v), 32'(digit_en), 32'(ed));
        check($sformatf("ovf v=%0d", v), 32'(ovf), 32'(eo));
        @(posedge clk);
        @(negedge clk);
        check($sformatf("done_pulse_len v=%0d", v), 32'({done, busy}), 32'd0);
        check($sformatf("hold_bcd v=%0d", v), 32'(bcd_out), 32'(eb));
        prev_bcd = eb;
        prev_den = ed;
        prev_ovf = eo;
    endtask

    initial begin
        int k, got, last, extra;

        // Reset, then idle with start low.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_idle", 32'({busy, done, ovf, digit_en, bcd_out}),
                  32'({1'b0, 1'b0, 1'b0, 4'b0001, 16'h0000}));
        end

        // Directed values, including saturation boundaries.
        convert(4581, 1'b0);
        convert(0, 1'b0);
        convert(7, 1'b0);
        convert(305, 1'b1);
        convert(9999, 1'b0);
        convert(10000, 1'b0);
        convert(12000, 1'b1);
        convert(16383, 1'b0);
        convert(10, 1'b0);

        // Back-to-back with start held high.
        start = 1'b1;
        bin = 14'd100;
        k = 0; got = 0; last = 0;
        while (got < 3 && k < 100) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (done) begin
                check($sformatf("b2b_bcd %0d", got), 32'(bcd_out), 32'(ref_bcd(100 + got)));
                if (got > 0) check($sformatf("b2b_spacing %0d", got), 32'(k - last), 32'd15);
                last = k;
                got++;
                bin = 14'(100 + got);
                if (got == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(got), 32'd3);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("b2b_no_extra", 32'(extra), 32'd0);
        prev_bcd = ref_bcd(102);
        prev_den = ref_den(102);
        prev_ovf = 1'b0;

        // Reset mid-conversion discards the result.
        start = 1'b1;
        bin = 14'd4581;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_outputs", 32'({busy, done, ovf, digit_en, bcd_out}),
              32'({1'b0, 1'b0, 1'b0, 4'b0001, 16'h0000}));
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("midrst_no_done", 32'(extra), 32'd0);
        check("midrst_hold", 32'({ovf, digit_en, bcd_out}), 32'({1'b0, 4'b0001, 16'h0000}));
        prev_bcd = 16'h0000;
        prev_den = 4'b0001;
        prev_ovf = 1'b0;
        convert(1234, 1'b0);

        // Random values across the full input range and below saturation.
        repeat (15) convert(int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)));
        repeat (15) convert(int'($urandom_range(0, 9999)), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
